// File: rtl/adc_align_ctrl.sv
// rtl/adc_align_ctrl.sv - link-training sequencer for one ADC IODELAY2/ISERDES2 receiver line
module adc_align_ctrl #(
    parameter logic [5:0] PATTERN   = 6'b111000,
    parameter int         SCAN_TAPS = 64,
    parameter int         SETTLE    = 8,
    parameter int         CHECK     = 16,
    parameter int         MIN_EYE   = 4,
    parameter int         INC_GAP   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [5:0] DOUT,
    input  logic       DBUSY,
    output logic       SRST,
    output logic       DRST,
    output logic       DCAL,
    output logic       DINC,
    output logic       BS,
    output logic       TRAINING,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] TAP,
    output logic [7:0] EYE_W,
    output logic [2:0] SLIPS
);

    typedef enum logic [3:0] {
        S_IDLE, S_SRST, S_CAL, S_SCAN, S_EVAL, S_RECENTRE, S_SLIP, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [1:0] {PH_SETTLE, PH_SAMPLE, PH_GAP} phase_t;

    state_t      state;
    phase_t      phase;
    logic [15:0] cnt;
    logic        busy_seen;
    logic [5:0]  first_word;
    logic        same;
    logic        match;
    logic [7:0]  run_len;
    logic [7:0]  run_start;
    logic [7:0]  best_len;
    logic [7:0]  best_start;
    logic [7:0]  centre;

    logic        same_now;
    logic        match_now;
    logic [7:0]  run_len_nx;
    logic [7:0]  run_start_nx;
    logic        settle_done;
    logic        last_sample;
    logic        gap_done;

    // Window accumulators include the word being sampled this cycle.
    always_comb begin
        same_now     = (cnt == 16'd0) || (same && (DOUT == first_word));
        match_now    = (DOUT == PATTERN) && ((cnt == 16'd0) || match);
        run_len_nx   = run_len + 8'd1;
        run_start_nx = (run_len == 8'd0) ? TAP : run_start;
        settle_done  = (cnt == 16'(SETTLE - 1));
        last_sample  = (cnt == 16'(CHECK - 1));
        gap_done     = (cnt == 16'(INC_GAP));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            phase      <= PH_SETTLE;
            cnt        <= '0;
            busy_seen  <= 1'b0;
            first_word <= '0;
            same       <= 1'b0;
            match      <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            centre     <= '0;
            SRST       <= 1'b0;
            DRST       <= 1'b0;
            DCAL       <= 1'b0;
            DINC       <= 1'b0;
            BS         <= 1'b0;
            TRAINING   <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            TAP        <= '0;
            EYE_W      <= '0;
            SLIPS      <= '0;
        end else begin
            DRST <= 1'b0;
            DCAL <= 1'b0;
            DINC <= 1'b0;
            BS   <= 1'b0;
            if (phase == PH_SAMPLE) begin
                first_word <= (cnt == 16'd0) ? DOUT : first_word;
                same       <= same_now;
                match      <= match_now;
            end
            case (state)
                S_IDLE: begin
                    if (START) begin
                        DONE     <= 1'b0;
                        ERR      <= 1'b0;
                        EYE_W    <= '0;
                        SLIPS    <= '0;
                        TRAINING <= 1'b1;
                        SRST     <= 1'b1;
                        DRST     <= 1'b1;
                        TAP      <= '0;
                        cnt      <= '0;
                        state    <= S_SRST;
                    end
                end
                S_SRST: begin
                    if (cnt == 16'd3) begin
                        SRST      <= 1'b0;
                        DCAL      <= 1'b1;
                        cnt       <= '0;
                        busy_seen <= 1'b0;
                        state     <= S_CAL;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CAL: begin
                    if (busy_seen && !DBUSY) begin
                        state      <= S_SCAN;
                        phase      <= PH_SETTLE;
                        cnt        <= '0;
                        run_len    <= '0;
                        run_start  <= '0;
                        best_len   <= '0;
                        best_start <= '0;
                    end else if (cnt == 16'd255) begin
                        state <= S_FAIL;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (DBUSY) busy_seen <= 1'b1;
                    end
                end
                S_SCAN: begin
                    case (phase)
                        PH_SETTLE: begin
                            if (settle_done) begin
                                phase <= PH_SAMPLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                        PH_SAMPLE: begin
                            if (!last_sample) begin
                                cnt <= cnt + 16'd1;
                            end else begin
                                // Best is updated as the run grows, so a run open at the last tap needs no special case.
                                if (same_now) begin
                                    run_len   <= run_len_nx;
                                    run_start <= run_start_nx;
                                    if (run_len_nx > best_len) begin
                                        best_len   <= run_len_nx;
                                        best_start <= run_start_nx;
                                    end
                                end else begin
                                    run_len <= '0;
                                end
                                if (TAP < 8'(SCAN_TAPS - 1)) begin
                                    DINC  <= 1'b1;
                                    TAP   <= TAP + 8'd1;
                                    phase <= PH_GAP;
                                    cnt   <= '0;
                                end else begin
                                    state <= S_EVAL;
                                end
                            end
                        end
                        default: begin
                            if (gap_done) begin
                                phase <= PH_SETTLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    endcase
                end
                S_EVAL: begin
                    EYE_W <= best_len;
                    if (best_len < 8'(MIN_EYE)) begin
                        state <= S_FAIL;
                    end else begin
                        centre <= best_start + {1'b0, best_len[7:1]};
                        DRST   <= 1'b1;
                        TAP    <= '0;
                        cnt    <= '0;
                        state  <= S_RECENTRE;
                    end
                end
                S_RECENTRE: begin
                    if (cnt == 16'd0) begin
                        if (TAP == centre) begin
                            state <= S_SLIP;
                            phase <= PH_SETTLE;
                        end else begin
                            DINC <= 1'b1;
                            TAP  <= TAP + 8'd1;
                            cnt  <= 16'd1;
                        end
                    end else begin
                        cnt <= gap_done ? 16'd0 : cnt + 16'd1;
                    end
                end
                S_SLIP: begin
                    if (phase == PH_SETTLE) begin
                        if (settle_done) begin
                            phase <= PH_SAMPLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else if (!last_sample) begin
                        cnt <= cnt + 16'd1;
                    end else if (match_now) begin
                        state <= S_DONE;
                    end else if (SLIPS == 3'd5) begin
                        state <= S_FAIL;
                    end else begin
                        BS    <= 1'b1;
                        SLIPS <= SLIPS + 3'd1;
                        phase <= PH_SETTLE;
                        cnt   <= '0;
                    end
                end
                S_DONE: begin
                    DONE     <= 1'b1;
                    TRAINING <= 1'b0;
                    state    <= S_IDLE;
                end
                S_FAIL: begin
                    ERR      <= 1'b1;
                    TRAINING <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_align_ctrl.sv
// tb/tb_adc_align_ctrl.sv - directed bench for adc_align_ctrl with an IODELAY/ISERDES line model
module tb_adc_align_ctrl;

    localparam logic [5:0] PAT    = 6'b111000;
    localparam int         SETTLE = 8;
    localparam int         CHECK  = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [5:0] DOUT = '0;
    logic       DBUSY = 1'b0;
    logic       SRST, DRST, DCAL, DINC, BS, TRAINING, DONE, ERR;
    logic [7:0] TAP, EYE_W;
    logic [2:0] SLIPS;

    adc_align_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .DOUT(DOUT), .DBUSY(DBUSY),
        .SRST(SRST), .DRST(DRST), .DCAL(DCAL), .DINC(DINC), .BS(BS),
        .TRAINING(TRAINING), .DONE(DONE), .ERR(ERR),
        .TAP(TAP), .EYE_W(EYE_W), .SLIPS(SLIPS)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int         n_eyes = 0;
    int         eye_lo[2];
    int         eye_hi[2];
    int         need = 0;
    bit         fixed_en = 1'b0;
    logic [5:0] fixed_word = '0;
    bit         stuck = 1'b0;

    int mtap = 0, rot = 0, busy_cnt = 0;
    int n_dinc = 0, n_drst = 0, n_bs = 0, n_srst = 0, n_dcal = 0, n_both = 0;
    int bs_close = 0, order_bad = 0, dinc_at_drst = 0, last_bs = -100000;
    int t_srst = 0, t_dcal = 0;

    // Line model: delay tap follows DRST/DINC, slip offset follows BS and clears on SRST.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (DRST) begin
            mtap         <= 0;
            n_drst       <= n_drst + 1;
            dinc_at_drst <= n_dinc;
        end else if (DINC) begin
            mtap <= mtap + 1;
        end
        if (DINC) begin
            n_dinc <= n_dinc + 1;
            if (t_dcal < t_srst) order_bad <= order_bad + 1;
        end
        if (DRST && DINC) n_both <= n_both + 1;
        if (SRST) begin
            rot    <= 0;
            n_srst <= n_srst + 1;
            t_srst <= cyc;
        end else if (BS) begin
            rot <= rot + 1;
        end
        if (BS) begin
            n_bs <= n_bs + 1;
            if (cyc - last_bs < SETTLE + CHECK) bs_close <= bs_close + 1;
            last_bs <= cyc;
        end
        if (DCAL) begin
            n_dcal   <= n_dcal + 1;
            t_dcal   <= cyc;
            busy_cnt <= 8;
            if (SRST) order_bad <= order_bad + 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    function automatic logic [5:0] word_at(int t, int r);
        logic [5:0] w;
        int k;
        for (int i = 0; i < n_eyes; i++) begin
            if (t >= eye_lo[i] && t <= eye_hi[i]) begin
                if (fixed_en) return fixed_word;
                w = PAT;
                k = (6 - need + r) % 6;
                for (int j = 0; j < k; j++) w = {w[4:0], w[5]};
                return w;
            end
        end
        return 6'($urandom);
    endfunction

    always @(negedge CLK) begin
        DBUSY = stuck || (busy_cnt > 0 && busy_cnt < 6);
        DOUT  = word_at(mtap, rot);
    end

    task automatic set_eyes(input int n, input int lo0, input int hi0, input int lo1, input int hi1,
                            input int nd, input bit fe, input logic [5:0] fw);
        n_eyes = n;
        eye_lo[0] = lo0; eye_hi[0] = hi0;
        eye_lo[1] = lo1; eye_hi[1] = hi1;
        need = nd;
        fixed_en = fe;
        fixed_word = fw;
    endtask

    task automatic train(output bit ok);
        ok = 1'b0;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (DONE || ERR) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL train_timeout: DONE=%0b ERR=%0b, required DONE or ERR within 20000 cycles", DONE, ERR);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({SRST, DRST, DCAL, DINC, BS} !== 5'd0) begin
            bad++;
            $display("FAIL reset_pulses: got %b want 00000", {SRST, DRST, DCAL, DINC, BS});
        end
        total++;
        if ({TRAINING, DONE, ERR, TAP, EYE_W, SLIPS} !== 22'd0) begin
            bad++;
            $display("FAIL reset_status: got %h want 0", {TRAINING, DONE, ERR, TAP, EYE_W, SLIPS});
        end
    endtask

    task automatic test_centre;
        bit ok;
        int b_dinc, b_drst, b_bs, b_both, b_ord, b_srst;
        set_eyes(1, 20, 35, 0, 0, 0, 1'b0, 6'd0);
        b_dinc = n_dinc; b_drst = n_drst; b_bs = n_bs; b_both = n_both; b_ord = order_bad; b_srst = n_srst;
        train(ok);
        total++; if (DONE !== 1'b1 || ERR !== 1'b0) begin bad++; $display("FAIL centre_done: DONE=%0b ERR=%0b want 1/0", DONE, ERR); end
        total++; if (EYE_W !== 8'd16) begin bad++; $display("FAIL centre_eye_w: got %0d want 16", EYE_W); end
        total++; if (TAP !== 8'd28) begin bad++; $display("FAIL centre_tap: got %0d want 28", TAP); end
        total++; if (SLIPS !== 3'd0) begin bad++; $display("FAIL centre_slips: got %0d want 0", SLIPS); end
        total++; if (dinc_at_drst - b_dinc !== 63) begin bad++; $display("FAIL centre_scan_dinc: got %0d want 63", dinc_at_drst - b_dinc); end
        total++; if (n_dinc - dinc_at_drst !== 28) begin bad++; $display("FAIL centre_recentre_dinc: got %0d want 28", n_dinc - dinc_at_drst); end
        total++; if (n_drst - b_drst !== 2) begin bad++; $display("FAIL centre_drst: got %0d want 2", n_drst - b_drst); end
        total++; if (n_srst - b_srst !== 4) begin bad++; $display("FAIL centre_srst_cycles: got %0d want 4", n_srst - b_srst); end
        total++; if (n_both - b_both !== 0) begin bad++; $display("FAIL centre_drst_dinc_overlap: got %0d want 0", n_both - b_both); end
        total++; if (order_bad - b_ord !== 0) begin bad++; $display("FAIL centre_phase_order: got %0d want 0", order_bad - b_ord); end
        total++; if (n_bs - b_bs !== 0) begin bad++; $display("FAIL centre_bs: got %0d want 0", n_bs - b_bs); end
    endtask

    task automatic test_slips;
        bit ok;
        int b_bs, b_close;
        set_eyes(1, 20, 35, 0, 0, 3, 1'b0, 6'd0);
        b_bs = n_bs; b_close = bs_close;
        train(ok);
        total++; if (DONE !== 1'b1 || ERR !== 1'b0) begin bad++; $display("FAIL slips_done: DONE=%0b ERR=%0b want 1/0", DONE, ERR); end
        total++; if (SLIPS !== 3'd3) begin bad++; $display("FAIL slips_count: got %0d want 3", SLIPS); end
        total++; if (n_bs - b_bs !== 3) begin bad++; $display("FAIL slips_bs_pulses: got %0d want 3", n_bs - b_bs); end
        total++; if (bs_close - b_close !== 0) begin bad++; $display("FAIL slips_bs_spacing: got %0d close pairs want 0", bs_close - b_close); end
        total++; if (TAP !== 8'd28) begin bad++; $display("FAIL slips_tap: got %0d want 28", TAP); end
    endtask

    task automatic test_tie;
        bit ok;
        set_eyes(2, 5, 12, 40, 47, 0, 1'b0, 6'd0);
        train(ok);
        total++; if (DONE !== 1'b1) begin bad++; $display("FAIL tie_done: got %0b want 1", DONE); end
        total++; if (EYE_W !== 8'd8) begin bad++; $display("FAIL tie_eye_w: got %0d want 8", EYE_W); end
        total++; if (TAP !== 8'd9) begin bad++; $display("FAIL tie_tap: got %0d want 9", TAP); end
    endtask

    task automatic test_open_end;
        bit ok;
        set_eyes(1, 60, 63, 0, 0, 0, 1'b0, 6'd0);
        train(ok);
        total++; if (DONE !== 1'b1 || ERR !== 1'b0) begin bad++; $display("FAIL open_done: DONE=%0b ERR=%0b want 1/0", DONE, ERR); end
        total++; if (EYE_W !== 8'd4) begin bad++; $display("FAIL open_eye_w: got %0d want 4", EYE_W); end
        total++; if (TAP !== 8'd62) begin bad++; $display("FAIL open_tap: got %0d want 62", TAP); end
    endtask

    task automatic test_no_eye;
        bit ok;
        int b_bs;
        set_eyes(0, 0, 0, 0, 0, 0, 1'b0, 6'd0);
        b_bs = n_bs;
        train(ok);
        total++; if (ERR !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL noeye_err: ERR=%0b DONE=%0b want 1/0", ERR, DONE); end
        total++; if (EYE_W >= 8'd4) begin bad++; $display("FAIL noeye_eye_w: got %0d want <4", EYE_W); end
        total++; if (n_bs - b_bs !== 0) begin bad++; $display("FAIL noeye_bs: got %0d want 0", n_bs - b_bs); end
        total++; if (TRAINING !== 1'b0) begin bad++; $display("FAIL noeye_training: got %0b want 0", TRAINING); end
    endtask

    task automatic test_no_match;
        bit ok;
        int b_bs;
        set_eyes(1, 20, 35, 0, 0, 0, 1'b1, 6'b101010);
        b_bs = n_bs;
        train(ok);
        total++; if (ERR !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL nomatch_err: ERR=%0b DONE=%0b want 1/0", ERR, DONE); end
        total++; if (SLIPS !== 3'd5) begin bad++; $display("FAIL nomatch_slips: got %0d want 5", SLIPS); end
        total++; if (n_bs - b_bs !== 5) begin bad++; $display("FAIL nomatch_bs: got %0d want 5", n_bs - b_bs); end
        total++; if (EYE_W !== 8'd16) begin bad++; $display("FAIL nomatch_eye_w: got %0d want 16", EYE_W); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        int b_drst, b_srst;
        set_eyes(1, 20, 35, 0, 0, 0, 1'b0, 6'd0);
        b_drst = n_drst; b_srst = n_srst;
        ok = 1'b0;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        repeat (300) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK) START = 1'b0;
        total++; if (TRAINING !== 1'b1) begin bad++; $display("FAIL ignore_training: got %0b want 1", TRAINING); end
        for (int i = 0; i < 20000; i++) begin
            if (DONE || ERR) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        total++; if (!ok) begin bad++; $display("FAIL ignore_timeout: DONE=%0b ERR=%0b want DONE or ERR", DONE, ERR); end
        total++; if (DONE !== 1'b1 || TAP !== 8'd28) begin bad++; $display("FAIL ignore_result: DONE=%0b TAP=%0d want 1/28", DONE, TAP); end
        total++; if (n_drst - b_drst !== 2 || n_srst - b_srst !== 4) begin
            bad++; $display("FAIL ignore_no_restart: drst=%0d srst=%0d want 2/4", n_drst - b_drst, n_srst - b_srst);
        end
    endtask

    task automatic test_rst_mid_scan;
        int b_dinc, b_drst, b_bs, b_srst, b_dcal;
        set_eyes(1, 20, 35, 0, 0, 0, 1'b0, 6'd0);
        b_dinc = n_dinc;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        repeat (800) @(negedge CLK);
        total++; if (TRAINING !== 1'b1 || n_dinc == b_dinc) begin
            bad++; $display("FAIL rst_in_scan: TRAINING=%0b dinc=%0d want 1/>0", TRAINING, n_dinc - b_dinc);
        end
        RST = 1'b1;
        #1;
        total++; if ({SRST, DRST, DCAL, DINC, BS, TRAINING, DONE, ERR, TAP, EYE_W, SLIPS} !== 27'd0) begin
            bad++; $display("FAIL rst_immediate: got %h want 0", {SRST, DRST, DCAL, DINC, BS, TRAINING, DONE, ERR, TAP, EYE_W, SLIPS});
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        b_dinc = n_dinc; b_drst = n_drst; b_bs = n_bs; b_srst = n_srst; b_dcal = n_dcal;
        repeat (200) @(negedge CLK);
        total++; if ((n_dinc - b_dinc) + (n_drst - b_drst) + (n_bs - b_bs) + (n_srst - b_srst) + (n_dcal - b_dcal) !== 0) begin
            bad++; $display("FAIL rst_quiet: got %0d pulses want 0",
                (n_dinc - b_dinc) + (n_drst - b_drst) + (n_bs - b_bs) + (n_srst - b_srst) + (n_dcal - b_dcal));
        end
        total++; if (TRAINING !== 1'b0 || TAP !== 8'd0) begin bad++; $display("FAIL rst_idle: TRAINING=%0b TAP=%0d want 0/0", TRAINING, TAP); end
    endtask

    task automatic test_dbusy_stuck;
        bit ok;
        int b_dinc, t0;
        set_eyes(1, 20, 35, 0, 0, 0, 1'b0, 6'd0);
        stuck = 1'b1;
        b_dinc = n_dinc;
        t0 = cyc;
        train(ok);
        total++; if (ERR !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL stuck_err: ERR=%0b DONE=%0b want 1/0", ERR, DONE); end
        total++; if (cyc - t0 < 256) begin bad++; $display("FAIL stuck_timeout_len: got %0d cycles want >=256", cyc - t0); end
        total++; if (n_dinc - b_dinc !== 0) begin bad++; $display("FAIL stuck_no_scan: got %0d DINC want 0", n_dinc - b_dinc); end
        stuck = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        test_reset;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        test_centre;
        test_slips;
        test_tie;
        test_open_end;
        test_no_eye;
        test_no_match;
        test_start_ignored;
        test_rst_mid_scan;
        test_dbusy_stuck;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_align_ctrl.md
Name: adc_align_ctrl

Overview:
- Link-training sequencer for one ADC deserializer line: the IODELAY2 + master/slave ISERDES2 6-bit DDR receiver.
- Resets the receiver and calibrates the delay.
- Scans the delay taps to find the widest stable eye and moves the delay to its centre.
- Bitslips until the word equals the ADC training pattern, then reports DONE, or ERR on failure.
- Sits between the receiver's control inputs and the channel's slow-control logic.

Parameters:
PATTERN, 6'b111000, expected 6-bit training word (ADC frame pattern)
SCAN_TAPS, 64, number of delay taps scanned (1..255)
SETTLE, 8, CLK cycles waited after any delay/bitslip change before sampling
CHECK, 16, consecutive words compared per decision
MIN_EYE, 4, minimum stable-tap run accepted
INC_GAP, 4, CLK cycles between successive DINC pulses

Ports:
CLK  in  1  fabric clock (the receiver's CLKDIV/IODELAY clock)
RST  in  1  asynchronous active-high reset
START  in  1  one-cycle request to (re)train
DOUT  in  6  deserialized word from receiver
DBUSY  in  1  IODELAY2 BUSY after CAL
SRST  out  1  ISERDES2 reset
DRST  out  1  IODELAY2 reset (counter to tap 0)
DCAL  out  1  IODELAY2 calibrate
DINC  out  1  IODELAY2 increment (drives both CE and INC)
BS  out  1  bitslip pulse
TRAINING  out  1  high from START accepted until DONE/ERR
DONE  out  1  level: aligned
ERR  out  1  level: alignment failed
TAP  out  8  current delay tap as tracked by this block
EYE_W  out  8  width of widest stable run found
SLIPS  out  3  bitslips applied in the last training

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; internal counters 0.
- All control pulses are exactly one CLK wide and registered. DRST and DINC are never both high in the same cycle.
- FSM:
  - IDLE: on START, clear DONE/ERR/EYE_W/SLIPS and set TRAINING=1 -> SRST_S.
  - SRST_S: SRST=1 for 4 cycles, with a DRST pulse in the first cycle. TAP<=0 -> CAL.
  - CAL: pulse DCAL, then wait for DBUSY to rise and then fall. Timeout of 256 cycles without completing gives ERR -> FAIL.
  - SCAN: for t=0..SCAN_TAPS-1:
    - wait SETTLE;
    - sample CHECK words; the tap is "stable" iff all CHECK words are equal to the first;
    - if t<SCAN_TAPS-1, pulse DINC, TAP<=TAP+1, then wait INC_GAP.
    - Track the current run (start, length) and the best run. Strictly longer replaces best, so ties keep the earliest run. A run still open at the last tap is evaluated at scan end.
  - EVAL: EYE_W<=best length. If best<MIN_EYE -> FAIL. Otherwise centre = best_start + floor(best_len/2) -> RECENTRE.
  - RECENTRE: pulse DRST, TAP<=0, then issue centre DINC pulses spaced INC_GAP, incrementing TAP each pulse -> SLIP.
  - SLIP: wait SETTLE, sample CHECK words.
    - All == PATTERN -> DONE state.
    - Any mismatch: if SLIPS==5 -> FAIL; else pulse BS, SLIPS<=SLIPS+1, repeat SLIP.
  - DONE state: DONE=1, TRAINING=0 -> IDLE (DONE held).
  - FAIL: ERR=1, TRAINING=0 -> IDLE (ERR held).
- START while TRAINING=1 is ignored. START in IDLE with DONE or ERR set restarts training.
- TAP never exceeds SCAN_TAPS-1. TAP is 8 bits, so no wrap within range.
- Word compare uses all 6 bits. The sample counter resets whenever a new sampling window begins.
- Latency, no-DBUSY case:
  - minimum ≈ 4 + CAL + SCAN_TAPS*(SETTLE+CHECK+1+INC_GAP) + centre*(INC_GAP+1) + (SLIPS+1)*(SETTLE+CHECK+1) cycles.
  - The bench checks the order of phases, not the exact total.

Test Plan:
- Eye at taps 20..35 (DOUT constant 6'b111000 in that range, random elsewhere), correct slip = 0 -> EYE_W=16, TAP=28, SLIPS=0, DONE=1, ERR=0. Exactly 63 scan DINC + 28 recentre DINC pulses, one DRST in recentre.
- Same eye, model needs 3 slips (stable word is a rotation of PATTERN) -> 3 BS pulses each ≥SETTLE+CHECK apart, SLIPS=3, DONE=1.
- Two equal eyes 5..12 and 40..47 -> earliest kept, EYE_W=8, TAP=9.
- Eye 60..63 (open at scan end) -> EYE_W=4, TAP=62, DONE.
- All taps random -> EYE_W<4, ERR=1, DONE=0, no BS pulses. Pattern never matches at the centre -> SLIPS=5, ERR=1.
- RST asserted mid-SCAN -> all outputs 0 immediately, no further pulses. START during training ignored. DBUSY stuck high -> ERR after 256-cycle timeout.
